// File: rtl/blwl_config_driver.sv
// Bank configuration programmer: streams words onto bl and strobes one wl row with programmable setup/pulse timing.
// Optional BLWL_AUTO_ADDR_EN: rows come from an internal wrapping counter instead of cfg_addr.
module blwl_config_driver #(
    parameter int BL_WIDTH     = 8,
    parameter int WL_WIDTH     = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    localparam int AW = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1
) (
    input  logic                prog_clk,
    input  logic                prog_reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [BL_WIDTH-1:0] cfg_data,
    input  logic [AW-1:0]       cfg_addr,
    input  logic                cfg_last,
    output logic [BL_WIDTH-1:0] bl,
    output logic [WL_WIDTH-1:0] wl,
    output logic                busy,
    output logic                done,
    output logic                addr_err
);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    localparam logic [3:0]          SETUP_LD = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0]          PULSE_LD = 4'(PULSE_CYCLES - 1);
    localparam logic [WL_WIDTH-1:0] WL_ONE   = WL_WIDTH'(1);

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] addr_q;
    logic          last_q;
    logic          addr_ok;
    logic [AW-1:0] next_addr;

`ifdef BLWL_AUTO_ADDR_EN
    localparam logic [AW-1:0] ROW_MAX = AW'(WL_WIDTH - 1);

    logic [AW-1:0] row;
    logic          unused_cfg_addr;

    assign unused_cfg_addr = ^cfg_addr;
    assign addr_ok         = 1'b1;
    assign next_addr       = row;
    assign addr_err        = 1'b0;

    // Advance once per strobed row; a completed bitstream restarts at row 0.
    always_ff @(posedge prog_clk) begin
        if (prog_reset)
            row <= '0;
        else if (state == PULSE && cnt == 4'd0)
            row <= (row == ROW_MAX) ? '0 : row + 1'b1;
        else if (state == HOLD && last_q)
            row <= '0;
    end
`else
    localparam logic [AW:0] WL_LIM = (AW+1)'(WL_WIDTH);

    assign addr_ok   = ({1'b0, cfg_addr} < WL_LIM);
    assign next_addr = cfg_addr;

    always_ff @(posedge prog_clk) begin
        if (prog_reset)
            addr_err <= 1'b0;
        else if (state == IDLE && cfg_valid && cfg_ready && !addr_ok)
            addr_err <= 1'b1;
    end
`endif

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state     <= IDLE;
            bl        <= '0;
            wl        <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= 4'd0;
            addr_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // Out-of-range words are dropped here; only the sticky flag records them.
                    if (cfg_valid && cfg_ready && addr_ok) begin
                        state     <= SETUP;
                        bl        <= cfg_data;
                        addr_q    <= next_addr;
                        last_q    <= cfg_last;
                        cnt       <= SETUP_LD;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        state <= PULSE;
                        wl    <= WL_ONE << addr_q;
                        cnt   <= PULSE_LD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                PULSE: begin
                    if (cnt == 4'd0) begin
                        state <= HOLD;
                        wl    <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    state     <= IDLE;
                    bl        <= '0;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                    done      <= last_q;
                    cnt       <= 4'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blwl_config_driver.sv
// Directed bench for blwl_config_driver: an 8x8 instance for timing/back-to-back/reset, a 6-row instance for range errors.
module tb_blwl_config_driver;

    logic       clk = 1'b0;
    logic       prog_reset;
    logic       cfg_valid, cfg_ready, cfg_last, busy, done, addr_err;
    logic [7:0] cfg_data, bl, wl;
    logic [2:0] cfg_addr;

    logic       v6, rdy6, last6, busy6, done6, aerr6;
    logic [7:0] d6, bl6;
    logic [2:0] a6;
    logic [5:0] wl6;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    blwl_config_driver #(.BL_WIDTH(8), .WL_WIDTH(8)) u_dut (
        .prog_clk(clk), .prog_reset(prog_reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_last(cfg_last), .bl(bl), .wl(wl),
        .busy(busy), .done(done), .addr_err(addr_err)
    );

    blwl_config_driver #(.BL_WIDTH(8), .WL_WIDTH(6)) u_dut6 (
        .prog_clk(clk), .prog_reset(prog_reset), .cfg_valid(v6), .cfg_ready(rdy6),
        .cfg_data(d6), .cfg_addr(a6), .cfg_last(last6), .bl(bl6), .wl(wl6),
        .busy(busy6), .done(done6), .addr_err(aerr6)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one word and walk its 5-cycle program sequence; returns in the following IDLE cycle.
    task automatic run_word(input logic [7:0] d, input logic [2:0] a, input logic l, input int row);
        logic [7:0] oh;
        oh = 8'(1) << row;
        cfg_valid = 1'b1; cfg_data = d; cfg_addr = a; cfg_last = l;
        tick;
        chk("setup_bl", bl, d);  chk("setup_wl", wl, 0);
        chk("setup_rdy", cfg_ready, 0); chk("setup_busy", busy, 1);
        tick;
        chk("pulse1_wl", wl, oh); chk("pulse1_bl", bl, d);
        tick;
        chk("pulse2_wl", wl, oh); chk("pulse2_bl", bl, d);
        tick;
        chk("hold_wl", wl, 0);   chk("hold_bl", bl, d);
        tick;
        chk("idle_rdy", cfg_ready, 1); chk("idle_done", done, l);
        chk("idle_bl", bl, 0);   chk("idle_busy", busy, 0);
    endtask

    initial begin
        prog_reset = 1'b1;
        cfg_valid = 1'b0; cfg_data = '0; cfg_addr = '0; cfg_last = 1'b0;
        v6 = 1'b0; d6 = '0; a6 = '0; last6 = 1'b0;
        tick; tick;
        prog_reset = 1'b0;
        chk("rst_bl", bl, 0);     chk("rst_wl", wl, 0);
        chk("rst_rdy", cfg_ready, 1); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_aerr", addr_err, 0);
        tick;
        chk("idle_wl", wl, 0);

        run_word(8'hA5, 3'd3, 1'b1, 3);
        cfg_valid = 1'b0;
        tick;
        chk("done_clr", done, 0);

`ifdef BLWL_AUTO_ADDR_EN
        for (int w = 0; w < 10; w++)
            run_word(8'hC0 + 8'(w), 3'd5, (w == 9), w % 8);
        run_word(8'h55, 3'd5, 1'b0, 0);
        cfg_valid = 1'b0;
        tick;
        chk("auto_aerr", addr_err, 0);
`else
        // Back-to-back stream: valid stays high, one word every 5 cycles.
        for (int w = 0; w < 8; w++)
            run_word(8'h10 + 8'(w), 3'(w), (w == 7), w);
        cfg_valid = 1'b0;
        tick;

        // Reset during the first PULSE cycle aborts the word.
        cfg_valid = 1'b1; cfg_data = 8'h5A; cfg_addr = 3'd2; cfg_last = 1'b1;
        tick;
        cfg_valid = 1'b0;
        tick;
        chk("mid_wl", wl, 8'h04);
        prog_reset = 1'b1;
        tick;
        prog_reset = 1'b0;
        chk("abort_wl", wl, 0);   chk("abort_bl", bl, 0);
        chk("abort_rdy", cfg_ready, 1); chk("abort_busy", busy, 0);
        tick;
        chk("abort_done", done, 0);
        tick;
        chk("abort_done2", done, 0);
        run_word(8'h77, 3'd1, 1'b1, 1);
        cfg_valid = 1'b0;
        tick;

        // Out-of-range row on the 6-row bank.
        v6 = 1'b1; d6 = 8'hEE; a6 = 3'd7; last6 = 1'b1;
        tick;
        v6 = 1'b0;
        chk("oor_aerr", aerr6, 1); chk("oor_wl", wl6, 0);
        chk("oor_rdy", rdy6, 1);   chk("oor_busy", busy6, 0);
        tick;
        chk("oor_done", done6, 0); chk("oor_wl2", wl6, 0);
        v6 = 1'b1; d6 = 8'h3C; a6 = 3'd5; last6 = 1'b0;
        tick;
        v6 = 1'b0;
        tick;
        chk("oor_next_wl", wl6, 6'h20); chk("oor_next_bl", bl6, 8'h3C);
        chk("oor_sticky", aerr6, 1);
        tick; tick; tick;
        chk("oor_next_rdy", rdy6, 1); chk("oor_next_done", done6, 0);
        chk("oor_sticky2", aerr6, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
